// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory port and the IF/ID register.
// One-entry skid buffer absorbs a word that returns while ID is stalled.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall_ID,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        IF_Flush,
   output logic [31:0] PC_IF,
   output logic [31:0] PC_sumado_IF,
   output logic [31:0] instruction_ID,
   output logic [31:0] PC_sumado_ID,
   output logic        valid_ID
);

   localparam logic [31:0] PC_STEP = 32'(PC_INC);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] pending_pc, pending_pc_next;
   logic        kill, kill_next;
   logic [31:0] skid_instr, skid_instr_next;
   logic [31:0] skid_sum, skid_sum_next;
   logic [31:0] instr_next, sum_next;
   logic        valid_next;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_sum;

   assign redirect     = jump | branch_taken;
   assign target       = jump ? jump_target : branch_target;
   assign pc_sum       = pc + PC_STEP;
   assign imem_req     = (state == REQ);
   assign imem_addr    = pc;
   assign PC_IF        = pc;
   assign PC_sumado_IF = pc_sum;

   always_comb begin
      state_next      = state;
      pc_next         = pc;
      pending_pc_next = pending_pc;
      kill_next       = kill;
      skid_instr_next = skid_instr;
      skid_sum_next   = skid_sum;
      instr_next      = instruction_ID;
      sum_next        = PC_sumado_ID;
      valid_next      = valid_ID;

      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            if (redirect) begin
               // The word in flight belongs to the wrong path; remember where to go if it is still pending.
               if (imem_ack) begin
                  pc_next   = target;
                  kill_next = 1'b0;
               end else begin
                  pending_pc_next = target;
                  kill_next       = 1'b1;
               end
               instr_next = NOP_WORD;
               sum_next   = 32'h0;
               valid_next = 1'b0;
            end else if (imem_ack && kill) begin
               pc_next   = pending_pc;
               kill_next = 1'b0;
               if (!stall_ID) begin
                  instr_next = NOP_WORD;
                  sum_next   = 32'h0;
                  valid_next = 1'b0;
               end
            end else if (imem_ack) begin
               pc_next = pc_sum;
               if (stall_ID) begin
                  skid_instr_next = imem_rdata;
                  skid_sum_next   = pc_sum;
                  state_next      = HOLD;
               end else begin
                  instr_next = imem_rdata;
                  sum_next   = pc_sum;
                  valid_next = 1'b1;
               end
            end else if (!stall_ID) begin
               instr_next = NOP_WORD;
               sum_next   = 32'h0;
               valid_next = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_next    = target;
               state_next = REQ;
               instr_next = NOP_WORD;
               sum_next   = 32'h0;
               valid_next = 1'b0;
            end else if (!stall_ID) begin
               instr_next = skid_instr;
               sum_next   = skid_sum;
               valid_next = 1'b1;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      // Flush only touches IF/ID; fetch-side state above still advances.
      if (IF_Flush) begin
         instr_next = NOP_WORD;
         sum_next   = 32'h0;
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         pending_pc     <= RESET_PC;
         kill           <= 1'b0;
         skid_instr     <= NOP_WORD;
         skid_sum       <= 32'h0;
         instruction_ID <= NOP_WORD;
         PC_sumado_ID   <= 32'h0;
         valid_ID       <= 1'b0;
      end else begin
         state          <= state_next;
         pc             <= pc_next;
         pending_pc     <= pending_pc_next;
         kill           <= kill_next;
         skid_instr     <= skid_instr_next;
         skid_sum       <= skid_sum_next;
         instruction_ID <= instr_next;
         PC_sumado_ID   <= sum_next;
         valid_ID       <= valid_next;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: transaction-level model plus directed vectors,
// and a second instance with RESET_PC at the top of the address space.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall_ID = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        IF_Flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr, PC_IF, PC_sumado_IF, instruction_ID, PC_sumado_ID;
   logic        valid_ID;

   logic        w_reset = 1'b1;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = 32'h0;
   logic        z_bit = 1'b0;
   logic [31:0] z_word = 32'h0;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_pc, w_pc_sum, w_instr, w_sum_id;

   int total_checks = 0;
   int bad_checks = 0;
   logic model_on = 1'b0;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] sum;
   } fetched_t;

   // Model state: fetch address, one pending redirect, words fetched but not yet taken by ID.
   logic        m_started;
   logic [31:0] m_pc, m_pend, m_instr, m_sum;
   logic        m_wrong, m_valid;
   fetched_t    m_buf[$];

   if_fetch_stage dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_ID(stall_ID),
      .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
      .jump_target(jump_target), .IF_Flush(IF_Flush), .PC_IF(PC_IF),
      .PC_sumado_IF(PC_sumado_IF), .instruction_ID(instruction_ID),
      .PC_sumado_ID(PC_sumado_ID), .valid_ID(valid_ID)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata), .stall_ID(z_bit),
      .branch_taken(z_bit), .branch_target(z_word), .jump(z_bit),
      .jump_target(z_word), .IF_Flush(z_bit), .PC_IF(w_pc),
      .PC_sumado_IF(w_pc_sum), .instruction_ID(w_instr),
      .PC_sumado_ID(w_sum_id), .valid_ID(w_valid)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_bubble();
      m_instr = 32'h0;
      m_sum   = 32'h0;
      m_valid = 1'b0;
   endtask

   task automatic model_step();
      logic        redirect;
      logic [31:0] target;
      logic        req;
      fetched_t    f;
      if (reset) begin
         m_started = 1'b0;
         m_pc      = 32'h0;
         m_pend    = 32'h0;
         m_wrong   = 1'b0;
         m_buf.delete();
         model_bubble();
         return;
      end
      redirect = jump | branch_taken;
      target   = jump ? jump_target : branch_target;
      req      = m_started && (m_buf.size() == 0);
      if (req && imem_ack) begin
         if (redirect || m_wrong) begin
            m_pc    = redirect ? target : m_pend;
            m_wrong = 1'b0;
         end else begin
            f.word = imem_rdata;
            f.sum  = m_pc + 32'd4;
            m_buf.push_back(f);
            m_pc = m_pc + 32'd4;
         end
      end else if (req && redirect) begin
         m_pend  = target;
         m_wrong = 1'b1;
      end else if (m_started && !req && redirect) begin
         m_buf.delete();
         m_pc = target;
      end
      if (m_started) begin
         if (redirect) model_bubble();
         else if (!stall_ID) begin
            if (m_buf.size() > 0) begin
               f = m_buf.pop_front();
               m_instr = f.word;
               m_sum   = f.sum;
               m_valid = 1'b1;
            end else model_bubble();
         end
      end
      if (IF_Flush) model_bubble();
      m_started = 1'b1;
   endtask

   task automatic checkOutput();
      check32("imem_req", {31'h0, imem_req}, {31'h0, m_started && (m_buf.size() == 0)});
      check32("imem_addr", imem_addr, m_pc);
      check32("PC_IF", PC_IF, m_pc);
      check32("PC_sumado_IF", PC_sumado_IF, m_pc + 32'd4);
      check32("instruction_ID", instruction_ID, m_instr);
      check32("PC_sumado_ID", PC_sumado_ID, m_sum);
      check32("valid_ID", {31'h0, valid_ID}, {31'h0, m_valid});
   endtask

   always @(negedge clk) begin
      if (model_on) checkOutput();
   end

   // Drive one cycle of inputs; memory returns addr ^ 0xA5A5 for both instances.
   task automatic applyStimulus(input logic rst, input logic ack, input logic stall,
                                input logic br, input logic [31:0] bt, input logic j,
                                input logic [31:0] jt, input logic fl);
      reset         = rst;
      imem_ack      = ack;
      stall_ID      = stall;
      branch_taken  = br;
      branch_target = bt;
      jump          = j;
      jump_target   = jt;
      IF_Flush      = fl;
      imem_rdata    = imem_addr ^ 32'h0000_A5A5;
      w_rdata       = w_addr ^ 32'h0000_A5A5;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic fetch(input logic ack, input logic stall);
      applyStimulus(1'b0, ack, stall, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      model_on = 1'b1;
      check32("reset imem_req", {31'h0, imem_req}, 32'h0);
      check32("reset valid_ID", {31'h0, valid_ID}, 32'h0);

      // T1: zero-wait memory
      fetch(1'b1, 1'b0);
      check32("T1 first addr", imem_addr, 32'h0);
      check32("T1 req up", {31'h0, imem_req}, 32'h1);
      check32("T1 valid still low", {31'h0, valid_ID}, 32'h0);
      fetch(1'b1, 1'b0);
      check32("T1 instr0", instruction_ID, 32'h0000_A5A5);
      check32("T1 sum0", PC_sumado_ID, 32'h4);
      check32("T1 valid", {31'h0, valid_ID}, 32'h1);
      check32("T1 model instr0", m_instr, 32'h0000_A5A5);
      fetch(1'b1, 1'b0);
      check32("T1 instr1", instruction_ID, 32'h0000_A5A1);
      check32("T1 addr2", imem_addr, 32'h8);

      // T2: two wait cycles on address 8
      fetch(1'b0, 1'b0);
      check32("T2 bubble1", {31'h0, valid_ID}, 32'h0);
      fetch(1'b0, 1'b0);
      check32("T2 addr held", imem_addr, 32'h8);
      check32("T2 bubble nop", instruction_ID, 32'h0);
      fetch(1'b1, 1'b0);
      check32("T2 word8", instruction_ID, 32'h0000_A5AD);
      check32("T2 sum8", PC_sumado_ID, 32'hC);

      // T3: stall while the word at 0xC returns; an ack during HOLD must be ignored
      fetch(1'b1, 1'b1);
      check32("T3 frozen", instruction_ID, 32'h0000_A5AD);
      check32("T3 hold req", {31'h0, imem_req}, 32'h0);
      fetch(1'b1, 1'b1);
      check32("T3 still frozen", PC_sumado_ID, 32'hC);
      fetch(1'b0, 1'b0);
      check32("T3 skid word", instruction_ID, 32'h0000_A5A9);
      check32("T3 skid sum", PC_sumado_ID, 32'h10);
      check32("T3 next addr", imem_addr, 32'h10);

      // T4: taken branch while the request at 0x10 is outstanding
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
      check32("T4 addr held", imem_addr, 32'h10);
      fetch(1'b1, 1'b0);
      check32("T4 killed word", {31'h0, valid_ID}, 32'h0);
      check32("T4 new addr", imem_addr, 32'h40);
      fetch(1'b1, 1'b0);
      check32("T4 target word", instruction_ID, 32'h0000_A5E5);

      // T5: jump beats branch, flush bubbles IF/ID
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
      check32("T5 jump addr", imem_addr, 32'h80);
      check32("T5 bubble", {31'h0, valid_ID}, 32'h0);
      fetch(1'b1, 1'b0);
      check32("T5 jump word", instruction_ID, 32'h0000_A525);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      check32("T5 flush over ack", {31'h0, valid_ID}, 32'h0);
      check32("T5 pc advanced", imem_addr, 32'h88);

      // Redirect while in HOLD drops the skid word
      fetch(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      check32("HOLD redirect addr", imem_addr, 32'h100);
      fetch(1'b1, 1'b0);
      check32("HOLD redirect word", instruction_ID, 32'h0000_A4A5);

      // T6a: reset mid-wait on the main instance, late ack ignored
      fetch(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      fetch(1'b1, 1'b0);
      check32("T6 late ack valid", {31'h0, valid_ID}, 32'h0);
      check32("T6 late ack addr", imem_addr, 32'h0);
      fetch(1'b1, 1'b0);
      check32("T6 restart word", instruction_ID, 32'h0000_A5A5);

      // T6b: PC wrap on the second instance
      w_reset = 1'b0;
      w_ack   = 1'b1;
      fetch(1'b0, 1'b0);
      check32("W first addr", w_addr, 32'hFFFF_FFFC);
      check32("W pc sum wrap", w_pc_sum, 32'h0);
      fetch(1'b0, 1'b0);
      check32("W second addr", w_addr, 32'h0);
      check32("W word", w_instr, 32'hFFFF_5A59);
      check32("W sum", w_sum_id, 32'h0);
      w_ack = 1'b0;
      fetch(1'b0, 1'b0);
      w_reset = 1'b1;
      fetch(1'b0, 1'b0);
      w_reset = 1'b0;
      w_ack   = 1'b1;
      fetch(1'b0, 1'b0);
      check32("W late ack valid", {31'h0, w_valid}, 32'h0);
      check32("W late ack instr", w_instr, 32'h0);
      check32("W reset addr", w_addr, 32'hFFFF_FFFC);
      check32("W req", {31'h0, w_req}, 32'h1);

      #10;
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
